// File: rtl/dqpsk_symbol_decoder.sv
// dqpsk_symbol_decoder
//   Integrate-and-dump symbol decoder that sits after the Costas carrier loop.
//   Each clk carries one I/Q sample. Samples are truncated to TW MSBs and summed
//   over a symbol window of SPS samples (SPS-1 or SPS+1 after a timing slip).
//   An early-late gate compares |I|+|Q| one sample either side of mid-symbol and
//   nudges the window by one sample once the signed error count hits LOCK_TH.
//   Dumped symbols are mapped to a quadrant and differentially decoded, so a
//   constant 90deg rotation of the constellation does not change the dibits.
//
// Ports
//   clk         in   system clock, one input sample per cycle
//   rst         in   synchronous reset, active-high
//   di, dq      in   26-bit signed I/Q samples from the carrier loop
//   sym_i/sym_q out  AW-bit signed integrated I/Q of the last completed symbol
//   dibit       out  differentially decoded Gray dibit
//   dvalid      out  one-cycle strobe, sym_i/sym_q/dibit are new
//   slip_early  out  one-cycle strobe with dvalid, next symbol is SPS-1 samples
//   slip_late   out  one-cycle strobe with dvalid, next symbol is SPS+1 samples

module dqpsk_symbol_decoder #(
    parameter int SPS     = 8,
    parameter int TW      = 16,
    parameter int AW      = 20,
    parameter int LOCK_TH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [25:0]   di,
    input  logic signed [25:0]   dq,
    output logic signed [AW-1:0] sym_i,
    output logic signed [AW-1:0] sym_q,
    output logic [1:0]           dibit,
    output logic                 dvalid,
    output logic                 slip_early,
    output logic                 slip_late
);

    localparam int CW   = $clog2(SPS + 2);
    localparam int ERRW = $clog2(LOCK_TH + 1) + 1;

    localparam logic [CW-1:0] LEN_NOM   = CW'(SPS);
    localparam logic [CW-1:0] LEN_SHORT = CW'(SPS - 1);
    localparam logic [CW-1:0] LEN_LONG  = CW'(SPS + 1);
    localparam logic [CW-1:0] E_CNT     = CW'(SPS / 2 - 1);
    localparam logic [CW-1:0] L_CNT     = CW'(SPS / 2 + 1);

    localparam logic signed [ERRW-1:0] TH_P    = ERRW'(LOCK_TH);
    localparam logic signed [ERRW-1:0] TH_N    = ERRW'(-LOCK_TH);
    localparam logic signed [ERRW-1:0] E_PLUS  = ERRW'(1);
    localparam logic signed [ERRW-1:0] E_MINUS = ERRW'(-1);
    localparam logic signed [ERRW-1:0] E_ZERO  = '0;

    // Magnitude that clamps the most-negative code to the largest positive one.
    function automatic logic [TW-2:0] abs_sat(input logic signed [TW-1:0] x);
        logic signed [TW-1:0] n;
        n = -x;
        if (x == {1'b1, {(TW-1){1'b0}}}) begin
            abs_sat = '1;
        end else if (x[TW-1]) begin
            abs_sat = n[TW-2:0];
        end else begin
            abs_sat = x[TW-2:0];
        end
    endfunction

    logic signed [TW-1:0] ti, tq;
    logic signed [AW-1:0] ti_x, tq_x;
    logic                 unused_lsbs;

    assign ti          = di[25 -: TW];
    assign tq          = dq[25 -: TW];
    assign ti_x        = {{(AW-TW){ti[TW-1]}}, ti};
    assign tq_x        = {{(AW-TW){tq[TW-1]}}, tq};
    assign unused_lsbs = ^{di[25-TW:0], dq[25-TW:0]};

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          len_q, len_d;
    logic signed [AW-1:0]   acc_i_q, acc_i_d;
    logic signed [AW-1:0]   acc_q_q, acc_q_d;
    logic [TW-1:0]          early_q, early_d;
    logic [TW-1:0]          late_q, late_d;
    logic signed [ERRW-1:0] err_q, err_d;
    logic                   first_q, first_d;
    logic [1:0]             qprev_q, qprev_d;
    logic signed [AW-1:0]   sym_i_q, sym_i_d;
    logic signed [AW-1:0]   sym_q_q, sym_q_d;
    logic [1:0]             dibit_q, dibit_d;
    logic                   dvalid_q, dvalid_d;
    logic                   slip_e_q, slip_e_d;
    logic                   slip_l_q, slip_l_d;

    logic                   last;
    logic signed [AW-1:0]   sum_i, sum_q;
    logic [TW-1:0]          mag_now, early_eff, late_eff;
    logic signed [ERRW-1:0] e_val, err_sum;
    logic [1:0]             quad, delta;

    always_comb begin
        last    = (cnt_q == len_q - CW'(1));
        sum_i   = (cnt_q == '0) ? ti_x : acc_i_q + ti_x;
        sum_q   = (cnt_q == '0) ? tq_x : acc_q_q + tq_x;
        mag_now = {1'b0, abs_sat(ti)} + {1'b0, abs_sat(tq)};

        // A gate point can coincide with the dump cycle, so use the live value there.
        early_eff = (cnt_q == E_CNT) ? mag_now : early_q;
        late_eff  = (cnt_q == L_CNT) ? mag_now : late_q;

        if (early_eff > late_eff) begin
            e_val = E_PLUS;
        end else if (early_eff < late_eff) begin
            e_val = E_MINUS;
        end else begin
            e_val = E_ZERO;
        end
        err_sum = err_q + e_val;

        // Quadrant from sign bits: (I>=0,Q>=0)=0, (I<0,Q>=0)=1, (I<0,Q<0)=2, (I>=0,Q<0)=3.
        quad  = {sum_q[AW-1], sum_i[AW-1] ^ sum_q[AW-1]};
        delta = quad - qprev_q;

        cnt_d    = cnt_q + CW'(1);
        len_d    = len_q;
        acc_i_d  = sum_i;
        acc_q_d  = sum_q;
        early_d  = early_eff;
        late_d   = late_eff;
        err_d    = err_q;
        first_d  = first_q;
        qprev_d  = qprev_q;
        sym_i_d  = sym_i_q;
        sym_q_d  = sym_q_q;
        dibit_d  = dibit_q;
        dvalid_d = 1'b0;
        slip_e_d = 1'b0;
        slip_l_d = 1'b0;

        if (last) begin
            cnt_d   = '0;
            len_d   = LEN_NOM;
            sym_i_d = sum_i;
            sym_q_d = sum_q;
            dibit_d = {delta[1], delta[1] ^ delta[0]};
            qprev_d = quad;
            first_d = 1'b0;
            // The first symbol after reset only seeds the phase reference; its
            // window is not yet trusted, so it does not feed the timing error.
            if (!first_q) begin
                dvalid_d = 1'b1;
                if (err_sum >= TH_P) begin
                    slip_e_d = 1'b1;
                    len_d    = LEN_SHORT;
                    err_d    = '0;
                end else if (err_sum <= TH_N) begin
                    slip_l_d = 1'b1;
                    len_d    = LEN_LONG;
                    err_d    = '0;
                end else begin
                    err_d = err_sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            len_q    <= LEN_NOM;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            early_q  <= '0;
            late_q   <= '0;
            err_q    <= '0;
            first_q  <= 1'b1;
            qprev_q  <= '0;
            sym_i_q  <= '0;
            sym_q_q  <= '0;
            dibit_q  <= '0;
            dvalid_q <= 1'b0;
            slip_e_q <= 1'b0;
            slip_l_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            early_q  <= early_d;
            late_q   <= late_d;
            err_q    <= err_d;
            first_q  <= first_d;
            qprev_q  <= qprev_d;
            sym_i_q  <= sym_i_d;
            sym_q_q  <= sym_q_d;
            dibit_q  <= dibit_d;
            dvalid_q <= dvalid_d;
            slip_e_q <= slip_e_d;
            slip_l_q <= slip_l_d;
        end
    end

    assign sym_i      = sym_i_q;
    assign sym_q      = sym_q_q;
    assign dibit      = dibit_q;
    assign dvalid     = dvalid_q;
    assign slip_early = slip_e_q;
    assign slip_late  = slip_l_q;

endmodule

// File: tb/tb_dqpsk_symbol_decoder.sv
module tb_dqpsk_symbol_decoder;

    localparam int SPS     = 8;
    localparam int TW      = 16;
    localparam int AW      = 20;
    localparam int LOCK_TH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [25:0]          di  = '0;
    logic [25:0]          dq  = '0;
    logic signed [AW-1:0] sym_i, sym_q;
    logic [1:0]           dibit;
    logic                 dvalid, slip_early, slip_late;

    int n_cmp = 0;
    int n_bad = 0;

    dqpsk_symbol_decoder #(.SPS(SPS), .TW(TW), .AW(AW), .LOCK_TH(LOCK_TH)) dut (
        .clk(clk), .rst(rst), .di(di), .dq(dq),
        .sym_i(sym_i), .sym_q(sym_q), .dibit(dibit),
        .dvalid(dvalid), .slip_early(slip_early), .slip_late(slip_late)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: buffers a whole symbol, then applies the decoding rules.
    int m_bi[$], m_bq[$];
    int m_len = SPS, m_err = 0, m_qprev = 0;
    bit m_first = 1;
    int m_sym_i = 0, m_sym_q = 0, m_dibit = 0;
    bit m_dv = 0, m_se = 0, m_sl = 0;

    function automatic int trunc16(input logic [25:0] x);
        logic signed [15:0] t;
        t = x[25:10];
        return int'(t);
    endfunction

    function automatic int mag(input int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int quadrant(input int i, input int q);
        if (i >= 0 && q >= 0) return 0;
        if (i < 0 && q >= 0)  return 1;
        if (i < 0)            return 2;
        return 3;
    endfunction

    function automatic void model(input logic r, input logic [25:0] a, input logic [25:0] b);
        int si, sq, ev, lv, e, qd, d;
        int gray[4] = '{0, 1, 3, 2};
        m_dv = 0; m_se = 0; m_sl = 0;
        if (r) begin
            m_bi.delete(); m_bq.delete();
            m_len = SPS; m_err = 0; m_qprev = 0; m_first = 1;
            m_sym_i = 0; m_sym_q = 0; m_dibit = 0;
            return;
        end
        m_bi.push_back(trunc16(a));
        m_bq.push_back(trunc16(b));
        if (m_bi.size() < m_len) return;
        si = 0; sq = 0;
        foreach (m_bi[k]) begin si += m_bi[k]; sq += m_bq[k]; end
        ev = mag(m_bi[SPS/2-1]) + mag(m_bq[SPS/2-1]);
        lv = mag(m_bi[SPS/2+1]) + mag(m_bq[SPS/2+1]);
        e  = (ev > lv) ? 1 : (ev < lv) ? -1 : 0;
        qd = quadrant(si, sq);
        d  = (qd - m_qprev + 4) % 4;
        m_sym_i = si; m_sym_q = sq; m_dibit = gray[d];
        m_qprev = qd;
        m_len = SPS;
        if (m_first) begin
            m_first = 0;
        end else begin
            m_dv = 1;
            m_err += e;
            if (m_err >= LOCK_TH) begin
                m_se = 1; m_len = SPS - 1; m_err = 0;
            end else if (m_err <= -LOCK_TH) begin
                m_sl = 1; m_len = SPS + 1; m_err = 0;
            end
        end
        m_bi.delete(); m_bq.delete();
    endfunction

    task automatic step(input logic r, input logic [25:0] a, input logic [25:0] b);
        rst = r; di = a; dq = b;
        @(posedge clk);
        model(r, a, b);
        #1;
        chk("dvalid", int'(dvalid), int'(m_dv));
        chk("slip_early", int'(slip_early), int'(m_se));
        chk("slip_late", int'(slip_late), int'(m_sl));
        if (m_dv || r) begin
            chk("sym_i", int'(sym_i), m_sym_i);
            chk("sym_q", int'(sym_q), m_sym_q);
            chk("dibit", int'(dibit), m_dibit);
        end
    endtask

    function automatic logic [25:0] pulse(input int t, input int pk);
        int d, v;
        d = (t % 8) - pk;
        if (d < 0) d = -d;
        v = 4 - d;
        if (v < 0) v = 0;
        return 26'(v * (1 << 20));
    endfunction

    function automatic logic [25:0] quad_val(input int qd, input bit is_q);
        int p = 1 << 20;
        if (!is_q) return ((qd == 1) || (qd == 2)) ? 26'(-p) : 26'(p);
        return (qd >= 2) ? 26'(-p) : 26'(p);
    endfunction

    int seq_a[6] = '{0, 1, 2, 3, 3, 0};
    int exp_dib[5] = '{1, 1, 1, 0, 1};

    initial begin
        int nv, n, t, qd;
        int got_dib[$];
        bit done;

        // Reset state
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        chk("rst_sym_i", int'(sym_i), 0);
        chk("rst_dvalid", int'(dvalid), 0);

        // Constant positive input
        nv = 0;
        for (int k = 0; k < 48; k++) begin
            step(1'b0, 26'(1 << 20), 26'(1 << 20));
            if (dvalid) nv++;
        end
        chk("t1_ndvalid", nv, 5);
        chk("t1_sym_i", int'(sym_i), 8192);
        chk("t1_dibit", int'(dibit), 0);

        // Quadrant sequence, then the same rotated by +90deg
        for (int rot = 0; rot < 2; rot++) begin
            step(1'b1, '0, '0);
            got_dib.delete();
            for (int s = 0; s < 6; s++) begin
                qd = (seq_a[s] + rot) % 4;
                for (int k = 0; k < SPS; k++) begin
                    step(1'b0, quad_val(qd, 0), quad_val(qd, 1));
                    if (dvalid) got_dib.push_back(int'(dibit));
                end
            end
            chk("t23_ndib", got_dib.size(), 5);
            for (int k = 0; k < 5 && k < got_dib.size(); k++)
                chk("t23_dibit", got_dib[k], exp_dib[k]);
        end

        // Early peak -> slip_early on 8th valid dump, 7-sample symbol follows
        // Late peak  -> slip_late, 9-sample symbol summed at full negative scale
        for (int pk_sel = 0; pk_sel < 2; pk_sel++) begin
            step(1'b1, '0, '0);
            nv = 0; t = 0; done = 0;
            for (int k = 0; k < 200 && !done; k++) begin
                step(1'b0, pulse(t, pk_sel ? 6 : 2), pulse(t, pk_sel ? 6 : 2));
                t++;
                if (dvalid) nv++;
                if (pk_sel == 0 && slip_early) done = 1;
                if (pk_sel == 1 && slip_late) done = 1;
            end
            chk("t45_slip_seen", int'(done), 1);
            chk("t45_slip_dump", nv, 8);
            n = 0; done = 0;
            for (int k = 0; k < 40 && !done; k++) begin
                if (pk_sel == 0) step(1'b0, pulse(t, 2), pulse(t, 2));
                else             step(1'b0, 26'h2000000, 26'h2000000);
                t++; n++;
                if (dvalid) done = 1;
            end
            chk("t45_slip_len", n, pk_sel ? 9 : 7);
            if (pk_sel == 1) chk("t5_fullscale", int'(sym_i), -294912);
        end

        // Reset at cnt=5 mid-symbol
        step(1'b1, '0, '0);
        for (int k = 0; k < SPS + 5; k++) step(1'b0, 26'(1 << 20), 26'(1 << 20));
        step(1'b1, 26'(1 << 20), 26'(1 << 20));
        chk("t6_sym_i", int'(sym_i), 0);
        chk("t6_sym_q", int'(sym_q), 0);
        chk("t6_dvalid", int'(dvalid), 0);
        n = 0; done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            step(1'b0, 26'(1 << 20), 26'(1 << 20));
            n++;
            if (dvalid) done = 1;
        end
        chk("t6_first_dv", n, 2 * SPS);

        // Random data with occasional resets
        step(1'b1, '0, '0);
        for (int k = 0; k < 800; k++)
            step(($urandom_range(0, 99) == 0), 26'($urandom), 26'($urandom));

        // Noisy pulses with random peak position to exercise slips
        for (int seg = 0; seg < 4; seg++) begin
            int pk;
            pk = $urandom_range(1, 6);
            step(1'b1, '0, '0);
            for (int k = 0; k < 300; k++)
                step(1'b0, pulse(k, pk) + 26'($urandom_range(0, 4095)),
                           pulse(k, pk) - 26'($urandom_range(0, 4095)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
